// File: rtl/ad_ch_avg_if.sv
// rtl/ad_ch_avg_if.sv - sample-in / average-out bus between AD7606 controller and averager
interface ad_ch_avg_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] ad_ch1;
  logic signed [DATA_W-1:0] ad_ch2;
  logic signed [DATA_W-1:0] ad_ch3;
  logic signed [DATA_W-1:0] ad_ch4;
  logic signed [DATA_W-1:0] ad_ch5;
  logic signed [DATA_W-1:0] ad_ch6;
  logic signed [DATA_W-1:0] ad_ch7;
  logic signed [DATA_W-1:0] ad_ch8;
  logic                     ad_vd;
  logic signed [DATA_W-1:0] avg_ch1;
  logic signed [DATA_W-1:0] avg_ch2;
  logic signed [DATA_W-1:0] avg_ch3;
  logic signed [DATA_W-1:0] avg_ch4;
  logic signed [DATA_W-1:0] avg_ch5;
  logic signed [DATA_W-1:0] avg_ch6;
  logic signed [DATA_W-1:0] avg_ch7;
  logic signed [DATA_W-1:0] avg_ch8;
  logic                     avg_vd;

  modport master (
    output ad_ch1, ad_ch2, ad_ch3, ad_ch4, ad_ch5, ad_ch6, ad_ch7, ad_ch8, ad_vd,
    input  avg_ch1, avg_ch2, avg_ch3, avg_ch4, avg_ch5, avg_ch6, avg_ch7, avg_ch8, avg_vd
  );

  modport slave (
    input  ad_ch1, ad_ch2, ad_ch3, ad_ch4, ad_ch5, ad_ch6, ad_ch7, ad_ch8, ad_vd,
    output avg_ch1, avg_ch2, avg_ch3, avg_ch4, avg_ch5, avg_ch6, avg_ch7, avg_ch8, avg_vd
  );
endinterface

// File: rtl/ad_ch_avg.sv
// rtl/ad_ch_avg.sv - eight-channel boxcar averager with one time-multiplexed adder
module ad_ch_avg #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  ad_ch_avg_if.slave  bus,
  output logic        ovr,
  output logic        busy
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]                state;
  logic [2:0]                idx;
  logic [AVG_LOG2-1:0]       smp_cnt;
  logic signed [DATA_W-1:0]  din [8];
  logic signed [DATA_W-1:0]  smp [8];
  logic signed [DATA_W-1:0]  avg [8];
  logic signed [ACC_W-1:0]   acc [8];
  logic signed [ACC_W-1:0]   sum;
  logic                      win_end;
  logic                      avg_vd_q;

  assign din[0] = bus.ad_ch1;
  assign din[1] = bus.ad_ch2;
  assign din[2] = bus.ad_ch3;
  assign din[3] = bus.ad_ch4;
  assign din[4] = bus.ad_ch5;
  assign din[5] = bus.ad_ch6;
  assign din[6] = bus.ad_ch7;
  assign din[7] = bus.ad_ch8;

  assign bus.avg_ch1 = avg[0];
  assign bus.avg_ch2 = avg[1];
  assign bus.avg_ch3 = avg[2];
  assign bus.avg_ch4 = avg[3];
  assign bus.avg_ch5 = avg[4];
  assign bus.avg_ch6 = avg[5];
  assign bus.avg_ch7 = avg[6];
  assign bus.avg_ch8 = avg[7];
  assign bus.avg_vd  = avg_vd_q;

  assign busy = (state == ACC);

  // Shared adder: running sum of the channel selected by idx plus its sign-extended sample
  always_comb begin
    sum     = acc[idx] + $signed({{AVG_LOG2{smp[idx][DATA_W-1]}}, smp[idx]});
    win_end = (smp_cnt == {AVG_LOG2{1'b1}});
  end

  // Window FSM: latch a conversion set in IDLE, then fold one channel per clock in ACC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      smp_cnt  <= '0;
      avg_vd_q <= 1'b0;
      ovr      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
        smp[i] <= '0;
        avg[i] <= '0;
      end
    end else if (clr) begin
      // restart the window; published averages are deliberately left untouched
      state    <= IDLE;
      idx      <= 3'd0;
      smp_cnt  <= '0;
      avg_vd_q <= 1'b0;
      ovr      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
      end
    end else begin
      avg_vd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ad_vd) begin
            for (int i = 0; i < 8; i++) begin
              smp[i] <= din[i];
            end
            idx   <= 3'd0;
            state <= ACC;
          end
        end
        ACC: begin
          // a set arriving mid-accumulation is dropped and flagged
          if (bus.ad_vd) begin
            ovr <= 1'b1;
          end
          if (win_end) begin
            // upper DATA_W bits of the sum are the arithmetic shift by AVG_LOG2 (floor)
            avg[idx] <= sum[AVG_LOG2 +: DATA_W];
            acc[idx] <= '0;
          end else begin
            acc[idx] <= sum;
          end
          if (idx == 3'd7) begin
            idx      <= 3'd0;
            smp_cnt  <= smp_cnt + 1'b1;
            avg_vd_q <= win_end;
            state    <= IDLE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
